// File: rtl/audio_pkg.sv
// Shared audio types and frame-geometry constants for the DAC serializer.
package audio_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int SLOT_BITS_DFLT   = 32;
  localparam int SAMPLE_BITS_DFLT = 16;
  localparam int FRAME_BITS       = 2 * SLOT_BITS_DFLT;
  localparam int BIT_IDX_W        = $clog2(FRAME_BITS);

endpackage

// File: rtl/audio_dac_serializer_bclk_divider.sv
// Bit-clock generator: BCLK toggles every BCLK_HALF_DIV cycles of clk,
// with single-cycle strobes on the clk edge where BCLK rises or falls.
module bclk_divider #(
  parameter int BCLK_HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic bclk_rise,
  output logic bclk_fall
);

  localparam int DIV_W = (BCLK_HALF_DIV > 1) ? $clog2(BCLK_HALF_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick      = (div == DIV_W'(BCLK_HALF_DIV - 1));
  assign bclk_rise = tick & ~bclk;
  assign bclk_fall = tick & bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (tick) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + 1'b1;
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmitter that also sources the synthesizer's frame clocks; the
// captured mono sample is sent on both the left and right slots.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 4,
  parameter int SLOT_BITS     = SLOT_BITS_DFLT,
  parameter int SAMPLE_BITS   = SAMPLE_BITS_DFLT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [SAMPLE_BITS-1:0] SAMPLE,
  input  logic                   MUTE,
  output logic                   SAMPLE_CLK,
  output logic                   FASTER_CLK,
  output logic                   AUD_BCLK,
  output logic                   AUD_DACLRCK,
  output logic                   AUD_DACDAT
);

  localparam int FRAME_LEN = 2 * SLOT_BITS;
  localparam int IDX_W     = $clog2(FRAME_LEN);

  logic                   bclk;
  logic                   bclk_fall;
  logic                   bclk_rise_unused;
  logic [IDX_W-1:0]       bit_idx;
  logic [IDX_W-1:0]       idx_next;
  logic                   lrck;
  logic                   dacdat;
  logic                   mute_q;
  logic [SAMPLE_BITS-1:0] tx_reg;
  logic [SAMPLE_BITS-1:0] pending;

  bclk_divider #(
    .BCLK_HALF_DIV(BCLK_HALF_DIV)
  ) u_bclk_divider (
    .clk      (CLK),
    .rst      (RESET),
    .bclk     (bclk),
    .bclk_rise(bclk_rise_unused),
    .bclk_fall(bclk_fall)
  );

  // I2S one-bit delay: slot position 0 is idle, the MSB sits at position 1.
  function automatic logic slot_bit(input logic [IDX_W-1:0] idx,
                                    input logic [SAMPLE_BITS-1:0] word);
    int                     p;
    logic [SAMPLE_BITS-1:0] sh;
    p        = int'(idx) % SLOT_BITS;
    slot_bit = 1'b0;
    if (p >= 1 && p <= SAMPLE_BITS) begin
      sh       = word >> (SAMPLE_BITS - p);
      slot_bit = sh[0];
    end
  endfunction

  assign idx_next = (bit_idx == IDX_W'(FRAME_LEN - 1)) ? '0 : bit_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bit_idx <= '0;
      lrck    <= 1'b0;
      dacdat  <= 1'b0;
      mute_q  <= 1'b0;
      tx_reg  <= '0;
      pending <= '0;
    end else if (bclk_fall) begin
      bit_idx <= idx_next;
      lrck    <= (int'(idx_next) >= SLOT_BITS);
      dacdat  <= ~mute_q & slot_bit(idx_next, tx_reg);
      // Capture on SAMPLE_CLK rise; the word goes out in the next frame.
      if (idx_next == IDX_W'(SLOT_BITS)) begin
        pending <= SAMPLE;
      end
      if (idx_next == '0) begin
        tx_reg <= MUTE ? '0 : pending;
        mute_q <= MUTE;
      end
    end
  end

  assign AUD_BCLK    = bclk;
  assign FASTER_CLK  = bclk;
  assign AUD_DACLRCK = lrck;
  assign SAMPLE_CLK  = lrck;
  assign AUD_DACDAT  = dacdat;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: cycle-count reference model, vector table
// of frame words, and hand-written sequences for reset, mute and capture timing.
module tb_audio_dac_serializer;
  import audio_pkg::*;

  localparam int HA = 4;
  localparam int HB = 1;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  sample_t sample_a = '0;
  sample_t sample_b = 16'h0001;
  logic    mute_a = 1'b0;
  logic    mute_b = 1'b0;
  logic    a_sclk, a_fclk, a_bclk, a_lrck, a_dat;
  logic    b_sclk, b_fclk, b_bclk, b_lrck, b_dat;

  always #5 clk = ~clk;

  audio_dac_serializer #(.BCLK_HALF_DIV(HA)) dut_a (
    .CLK(clk), .RESET(rst), .SAMPLE(sample_a), .MUTE(mute_a),
    .SAMPLE_CLK(a_sclk), .FASTER_CLK(a_fclk), .AUD_BCLK(a_bclk),
    .AUD_DACLRCK(a_lrck), .AUD_DACDAT(a_dat)
  );

  audio_dac_serializer #(.BCLK_HALF_DIV(HB)) dut_b (
    .CLK(clk), .RESET(rst), .SAMPLE(sample_b), .MUTE(mute_b),
    .SAMPLE_CLK(b_sclk), .FASTER_CLK(b_fclk), .AUD_BCLK(b_bclk),
    .AUD_DACLRCK(b_lrck), .AUD_DACDAT(b_dat)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: k = clk edges since reset; frame word changes only at wrap.
  int      ka, kb;
  sample_t capa, wa, capb, wb;

  always @(posedge clk) begin
    if (rst) begin
      ka <= 0; capa <= '0; wa <= '0;
      kb <= 0; capb <= '0; wb <= '0;
    end else begin
      ka <= ka + 1;
      if ((ka + 1) % (2 * HA) == 0) begin
        if (((ka + 1) / (2 * HA)) % 64 == 32) capa <= sample_a;
        if (((ka + 1) / (2 * HA)) % 64 == 0)  wa <= mute_a ? '0 : capa;
      end
      kb <= kb + 1;
      if ((kb + 1) % (2 * HB) == 0) begin
        if (((kb + 1) / (2 * HB)) % 64 == 32) capb <= sample_b;
        if (((kb + 1) / (2 * HB)) % 64 == 0)  wb <= mute_b ? '0 : capb;
      end
    end
  end

  function automatic logic [4:0] model_out(int k, int h, sample_t w);
    int      idx, p;
    logic    bc, lr, d;
    sample_t sh;
    idx = (k / (2 * h)) % 64;
    p   = idx % 32;
    bc  = ((k / h) % 2) == 1;
    lr  = idx >= 32;
    d   = 1'b0;
    if (p >= 1 && p <= 16) begin
      sh = w >> (16 - p);
      d  = sh[0];
    end
    return {bc, lr, d, bc, lr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_a", {27'b0, a_bclk, a_lrck, a_dat, a_fclk, a_sclk},
            {27'b0, model_out(ka, HA, wa)});
      check("cycle_b", {27'b0, b_bclk, b_lrck, b_dat, b_fclk, b_sclk},
            {27'b0, model_out(kb, HB, wb)});
    end
  end

  logic pa_bclk, pa_lrck, pb_bclk, pb_lrck;

  task automatic step();
    pa_bclk = a_bclk; pa_lrck = a_lrck;
    pb_bclk = b_bclk; pb_lrck = b_lrck;
    @(negedge clk);
  endtask

  // kind: 0 frame start, 1 lrck rise, 2 bclk rise, 3 bclk fall
  task automatic wait_ev(input bit sel, input int kind, input string name);
    bit   hit;
    logic bc, pbc, lr, plr;
    hit = 1'b0;
    for (int n = 0; n < 4000 && !hit; n++) begin
      step();
      bc  = sel ? b_bclk  : a_bclk;
      pbc = sel ? pb_bclk : pa_bclk;
      lr  = sel ? b_lrck  : a_lrck;
      plr = sel ? pb_lrck : pa_lrck;
      case (kind)
        0:       hit = plr && !lr;
        1:       hit = !plr && lr;
        2:       hit = bc && !pbc;
        default: hit = !bc && pbc;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: got no event expected one within 4000 cycles", name);
    end
  endtask

  task automatic collect(input bit sel, output logic [31:0] l, output logic [31:0] r);
    logic d;
    l = '0;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      wait_ev(sel, 2, "bclk_rise");
      d = sel ? b_dat : a_dat;
      if (i < 32) l = {l[30:0], d};
      else        r = {r[30:0], d};
    end
  endtask

  task automatic measure(input bit sel, input int exp_period, input string name);
    int   n, lo, rises, first_rise, second_rise;
    logic bc, pbc, lr, plr;
    bit   done;
    wait_ev(sel, 1, "lrck_rise");
    n = 0; lo = 0; rises = 0; first_rise = -1; second_rise = -1; done = 1'b0;
    while (!done && n < 4000) begin
      step();
      n++;
      bc  = sel ? b_bclk  : a_bclk;
      pbc = sel ? pb_bclk : pa_bclk;
      lr  = sel ? b_lrck  : a_lrck;
      plr = sel ? pb_lrck : pa_lrck;
      if (!lr) lo++;
      if (bc && !pbc) begin
        rises++;
        if (first_rise < 0) first_rise = n;
        else if (second_rise < 0) second_rise = n;
      end
      done = !plr && lr;
    end
    check({name, "_frame_period"}, n, exp_period);
    check({name, "_lrck_low"}, lo, exp_period / 2);
    check({name, "_bclk_per_frame"}, rises, 64);
    check({name, "_bclk_period"}, second_rise - first_rise, exp_period / 64);
  endtask

  typedef struct {
    sample_t smp;
    logic    mute;
    sample_t exp_word;
  } vec_t;

  vec_t        vt[6];
  logic [31:0] l, r, exp_slot;
  logic        any;
  int          n;

  initial begin
    vt[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
    vt[1] = '{16'h7FFF, 1'b0, 16'h7FFF};
    vt[2] = '{16'h8000, 1'b0, 16'h8000};
    vt[3] = '{16'h1234, 1'b1, 16'h0000};
    vt[4] = '{16'hFFFF, 1'b0, 16'hFFFF};
    vt[5] = '{16'h0001, 1'b0, 16'h0001};

    repeat (3) @(negedge clk);
    check("reset_outputs", {22'b0, a_sclk, a_fclk, a_bclk, a_lrck, a_dat,
                            b_sclk, b_fclk, b_bclk, b_lrck, b_dat}, 32'h0);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Free-running timing on both builds; first two frames carry zeros.
    measure(1'b0, 512, "a");
    measure(1'b1, 128, "b");

    wait_ev(1'b1, 0, "b_frame");
    collect(1'b1, l, r);
    check("b_only_p16_left", l, 32'h0000_8000);
    check("b_only_p16_right", r, 32'h0000_8000);

    for (int i = 0; i < 6; i++) begin
      wait_ev(1'b0, 0, "frame");
      sample_a = vt[i].smp;
      mute_a   = vt[i].mute;
      wait_ev(1'b0, 0, "frame");
      collect(1'b0, l, r);
      exp_slot = {1'b0, vt[i].exp_word, 15'b0};
      check($sformatf("vec%0d_left", i), l, exp_slot);
      check($sformatf("vec%0d_right", i), r, exp_slot);
    end
    mute_a = 1'b0;

    // Sample changes one clk after the capture edge.
    wait_ev(1'b0, 0, "frame");
    sample_a = 16'h7FFF;
    wait_ev(1'b0, 1, "capture");
    sample_a = 16'h8000;
    wait_ev(1'b0, 0, "frame");
    collect(1'b0, l, r);
    check("late_change_keeps_7fff", l, {1'b0, 16'h7FFF, 15'b0});
    wait_ev(1'b0, 0, "frame");
    collect(1'b0, l, r);
    check("late_change_next_8000", r, {1'b0, 16'h8000, 15'b0});

    // Mute raised mid right slot, dropped right after the wrap.
    wait_ev(1'b0, 0, "frame");
    sample_a = 16'h1234;
    wait_ev(1'b0, 1, "capture");
    repeat (8) wait_ev(1'b0, 3, "bclk_fall");
    mute_a = 1'b1;
    wait_ev(1'b0, 0, "frame");
    mute_a = 1'b0;
    collect(1'b0, l, r);
    check("muted_frame", {l[15:0], r[15:0]} | {l[31:16], r[31:16]}, 32'h0);
    wait_ev(1'b0, 0, "frame");
    collect(1'b0, l, r);
    check("unmuted_left", l, {1'b0, 16'h1234, 15'b0});
    check("unmuted_right", r, {1'b0, 16'h1234, 15'b0});

    // Reset pulse at bit_idx 20 of a frame carrying a non-zero word.
    wait_ev(1'b0, 0, "frame");
    repeat (20) wait_ev(1'b0, 3, "bclk_fall");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midframe_reset_outputs", {27'b0, a_sclk, a_fclk, a_bclk, a_lrck, a_dat}, 32'h0);
    n = 0;
    while (!a_bclk && n < 100) begin
      step();
      n++;
    end
    check("first_bclk_rise_delay", n, HA);
    any = a_dat;
    for (int i = 0; i < 63; i++) begin
      wait_ev(1'b0, 2, "bclk_rise");
      any = any | a_dat;
    end
    check("no_stale_bits", {31'b0, any}, 32'h0);

    // Randomized traffic checked by the cycle model.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) sample_a = sample_t'($urandom);
      if ($urandom_range(0, 9) == 0)  sample_b = sample_t'($urandom);
      if ($urandom_range(0, 299) == 0) mute_a = ~mute_a;
      if ($urandom_range(0, 99) == 0)  mute_b = ~mute_b;
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- Consumer end of the synthesizer's sample interface.
- Generates the frame timing the synthesizer runs on:
  - SAMPLE_CLK: one rising edge per frame.
  - FASTER_CLK: exactly 64× SAMPLE_CLK.
- Captures the synthesizer's Sample output on each SAMPLE_CLK rising edge.
- Serializes that sample in I2S format to the board audio DAC, on both left and right slots (mono duplicated).
- Sits between PolyphonicSynthesizer and the AUD_* codec pins.

Parameters:
- BCLK_HALF_DIV, 4: CLK cycles per BCLK half-period; legal range ≥1.
- SLOT_BITS, 32: BCLK periods per channel slot; frame = 2*SLOT_BITS = 64.
- SAMPLE_BITS, 16: width of the transmitted sample; must be < SLOT_BITS.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- SAMPLE  in  16  signed Sample from the synthesizer; valid at the SAMPLE_CLK rising edge.
- MUTE  in  1  when high at a frame boundary, the next frame transmits zeros.
- SAMPLE_CLK  out  1  frame clock for the synthesizer (equals AUD_DACLRCK).
- FASTER_CLK  out  1  64× frame clock for the synthesizer (equals AUD_BCLK).
- AUD_BCLK  out  1  DAC bit clock.
- AUD_DACLRCK  out  1  DAC word select; 0 = left, 1 = right.
- AUD_DACDAT  out  1  DAC serial data, MSB first.

Behaviour:
- Reset values:
  - div=0, bit_idx=0, BCLK=0, LRCK=0, DACDAT=0.
  - tx_reg=0, pending=0, mute_q=0.
  - All outputs 0.
- Divider:
  - div counts 0..BCLK_HALF_DIV-1.
  - On the CLK edge where div==BCLK_HALF_DIV-1: div←0 and BCLK toggles.
  - BCLK period = 2*BCLK_HALF_DIV CLK cycles.
  - First BCLK rise occurs BCLK_HALF_DIV cycles after RESET deasserts.
- Falling-edge event (BCLK toggling 1→0):
  - bit_idx←(bit_idx+1) mod 64.
  - LRCK and DACDAT update on the same CLK edge, so they change coincident with BCLK falling. The DAC samples on BCLK rising.
- LRCK:
  - 0 for bit_idx 0..31, 1 for bit_idx 32..63; i.e. bit_idx[5] of the new index.
  - SAMPLE_CLK = LRCK, so its rising edge marks the start of the right slot.
- Data mapping (I2S one-bit delay), per slot position p = bit_idx mod 32:
  - DACDAT = tx_reg[SAMPLE_BITS-p] for p in 1..SAMPLE_BITS.
  - DACDAT = 0 for p = 0 and for p > SAMPLE_BITS.
  - Both slots carry the same tx_reg.
- Capture:
  - On the falling-edge event where bit_idx goes 31→32 (SAMPLE_CLK rising): pending←SAMPLE.
  - SAMPLE is sampled on this CLK edge.
- Frame load:
  - On the falling-edge event where bit_idx goes 63→0: tx_reg←(MUTE ? 0 : pending); mute_q←MUTE.
- Latency:
  - The MSB of a captured sample appears on DACDAT at bit_idx 1 of the next frame.
  - That is 33 BCLK periods after the capture edge.
- Wrap-around: bit_idx 63→0 wraps with no gap; frames are contiguous.
- Simultaneous events: capture and frame load never coincide (bit_idx 32 vs 0). MUTE is only sampled at frame load.
- RESET mid-frame: all state returns to reset values on the next CLK edge. The partial frame is discarded. The pending sample is lost (tx_reg=0).
- BCLK_HALF_DIV=1: BCLK=CLK/2; all rules above are unchanged.
- Arithmetic:
  - Sample is passed bit-exact; no scaling or rounding.
  - SAMPLE is treated as a raw 16-bit two's-complement word.

Decomposition:
- Package audio_pkg holds:
  - the Sample typedef (already shared);
  - localparams FRAME_BITS = 2*SLOT_BITS and BIT_IDX_W = $clog2(FRAME_BITS).
- One natural sub-module, bclk_divider:
  - Outputs BCLK plus single-cycle pulses bclk_rise and bclk_fall (CLK-domain strobes).
  - The serializer acts only on bclk_fall.
- The serializer uses no derived clocks internally; AUD_BCLK/FASTER_CLK/SAMPLE_CLK are registered outputs only.

Test Plan:
- Reset then free-run 2 frames → AUD_BCLK period 8 CLK cycles; SAMPLE_CLK period 512 CLK cycles, high for 256; FASTER_CLK/SAMPLE_CLK edge ratio exactly 64; DACDAT all 0 (tx_reg=0).
- SAMPLE=16'hA5C3 held across SAMPLE_CLK rise → next frame: left and right slots each show p1..p16 = 1010010111000011; p0 and p17..31 = 0; bits sampled on AUD_BCLK rising.
- SAMPLE changes 16'h7FFF→16'h8000 one CLK after the capture edge → transmitted word is 16'h7FFF; 16'h8000 is not sent until after the next capture.
- MUTE=1 asserted at bit_idx 40 with SAMPLE=16'h1234 → following frame DACDAT all 0; MUTE=0 before the next 63→0 wrap → subsequent frame sends the latest captured sample.
- RESET pulsed for 1 cycle at bit_idx 20 → next cycle all outputs 0, bit_idx=0; first AUD_BCLK rise after BCLK_HALF_DIV cycles; no stale bits of the prior sample appear.
- BCLK_HALF_DIV=1 build, SAMPLE=16'h0001 → AUD_BCLK = CLK/2, frame = 128 CLK; only p16 of each slot is 1.
